// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the video
// fetch port and the CPU. Even clk slots belong to video, odd slots to the CPU.
// CPU writes are posted through a small FIFO. A CPU read first waits for that
// FIFO to drain, so reads always see every earlier write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no read in progress, posted writes may be accepted
// DRAIN    | read pending, waiting for FIFO empty and a CPU slot next
// RD_ISSUE | CPU slot carrying the read address to the VRAM
// RD_CAPT  | video slot in which the read data returns and is captured
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vid_add,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_phase,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_add,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_add,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, RD_ISSUE, RD_CAPT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_add  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Full is judged on the pre-pop count, so a full FIFO refuses a push even when it pops.
    assign push = cpu_req & cpu_we & ~full & ~cpu_ack & (state == IDLE);
    // The FIFO head owns every CPU slot except the one carrying a read address.
    assign pop  = vid_phase & ~empty & (state != RD_ISSUE);

    // Slot owner drives the VRAM port; ram_we is purely decoded so reset kills it at once.
    always_comb begin
        ram_add   = vid_add;
        ram_we    = 1'b0;
        ram_wdata = fifo_data[rd_ptr];
        if (vid_phase) begin
            if (state == RD_ISSUE) begin
                ram_add = cpu_add;
            end else if (!empty) begin
                ram_add = fifo_add[rd_ptr];
                ram_we  = 1'b1;
            end
        end
    end

    // Slot phase toggles every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_phase <= 1'b0;
        end else begin
            vid_phase <= ~vid_phase;
        end
    end

    // Video data is captured only at the edge closing a CPU slot (read data for the prior video slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_data <= '0;
        end else if (vid_phase) begin
            vid_data <= ram_rdata;
        end
    end

    // FIFO storage; stale contents are harmless because the pointers and count reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_add[wr_ptr]  <= cpu_add;
            fifo_data[wr_ptr] <= cpu_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read sequencer plus the registered CPU handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= push;
            case (state)
                IDLE: begin
                    if (cpu_req && !cpu_we && !cpu_ack) state <= DRAIN;
                end
                DRAIN: begin
                    if (empty && !vid_phase) state <= RD_ISSUE;
                end
                RD_ISSUE: begin
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ack   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural
// registered-read VRAM model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] vid_add;
    logic [7:0]  vid_data;
    logic        vid_phase;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_add;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [14:0] ram_add;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:32767];
    logic [7:0]  shadow [0:31];

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int bad_we = 0;

    typedef struct {
        logic [14:0] add;
        logic [7:0]  exp;
    } vid_vec_t;

    typedef struct {
        logic [14:0] add;
        logic [7:0]  dat;
    } wr_vec_t;

    vid_vec_t vid_tab [6];
    wr_vec_t  wr_tab  [6];

    vram_arbiter #(.ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_add(vid_add), .vid_data(vid_data), .vid_phase(vid_phase),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_add(cpu_add),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_add(ram_add), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read single-port VRAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_add] <= ram_wdata;
        ram_rdata <= mem[ram_add];
    end

    // Slot monitor: counts write slots and flags any write in a video slot.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) we_cnt <= we_cnt + 1;
            if (ram_we && !vid_phase) bad_we <= bad_we + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_ack_timeout"}, 0, 1);
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = a; cpu_wdata = d;
        wait_ack("wr");
        cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [14:0] a, output logic [7:0] d);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_add = a; cpu_wdata = 8'h00;
        wait_ack("rd");
        d = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    task automatic align_video;
        if (vid_phase) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [14:0] va;
        int          base_we;
        bit          done;
        bit          found;

        for (int i = 0; i < 32768; i++) mem[i] = pix(15'(i));
        mem[15'h0000] = 8'hA5;
        mem[15'h00A0] = 8'h5A;
        mem[15'h7D10] = 8'hEE;

        vid_tab[0] = '{15'h0000, 8'hA5};
        vid_tab[1] = '{15'h00A0, 8'h5A};
        vid_tab[2] = '{15'h1234, 8'h1A};
        vid_tab[3] = '{15'h7CFF, 8'hBF};
        vid_tab[4] = '{15'h4000, 8'h7C};
        vid_tab[5] = '{15'h7D10, 8'hEE};
        for (int i = 0; i < 6; i++) wr_tab[i] = '{15'h7D00 + 15'(i), 8'h10 + 8'(i)};

        rst_n = 1'b0; vid_add = '0; cpu_req = 0; cpu_we = 0; cpu_add = '0; cpu_wdata = '0;

        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_vid_data", vid_data, 8'h00);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_phase", vid_phase, 0);
        rst_n = 1'b1;
        #1 check("phase_after_release", vid_phase, 0);
        @(negedge clk) check("phase_toggle1", vid_phase, 1);
        @(negedge clk) check("phase_toggle2", vid_phase, 0);

        // 2. video fetch table
        for (int i = 0; i < 6; i++) begin
            align_video();
            vid_add = vid_tab[i].add;
            @(negedge clk);
            @(negedge clk);
            check($sformatf("vid_fetch_%0h", vid_tab[i].add), vid_data, vid_tab[i].exp);
        end

        // 3. six back-to-back posted writes
        for (int i = 0; i < 6; i++) cpu_write(wr_tab[i].add, wr_tab[i].dat);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++)
            check($sformatf("wr_mem_%0h", wr_tab[i].add), mem[wr_tab[i].add], wr_tab[i].dat);

        // 4. write then immediate read of the same location
        base_we = we_cnt;
        cpu_write(15'h7D00, 8'h3C);
        cpu_read(15'h7D00, rd);
        check("raw_rdata", rd, 8'h3C);
        repeat (6) @(negedge clk);
        check("raw_one_we", we_cnt - base_we, 1);
        check("rdata_held", cpu_rdata, 8'h3C);

        // 5. reset while a posted write is being drained
        cpu_write(15'h7D08, 8'hA1);
        cpu_write(15'h7D09, 8'hA2);
        cpu_write(15'h7D0A, 8'hA3);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (ram_we) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("drain_we_seen", found, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_we", ram_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base_we = we_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_no_we", we_cnt - base_we, 0);
        check("post_rst_count", dut.count, 0);

        // 6. random CPU traffic against a sweeping video fetch
        for (int i = 0; i < 32; i++) shadow[i] = mem[15'h7D00 + 15'(i)];
        done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int          off;
                    logic [7:0]  d;
                    off = $urandom_range(0, 31);
                    d   = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        cpu_write(15'h7D00 + 15'(off), d);
                        shadow[off] = d;
                    end else begin
                        cpu_read(15'h7D00 + 15'(off), rd);
                        check($sformatf("rand_rd_%0h", 15'h7D00 + 15'(off)), rd, shadow[off]);
                    end
                end
                done = 1;
            end
            begin
                align_video();
                va = 15'h0100;
                vid_add = va;
                while (!done) begin
                    @(negedge clk);
                    @(negedge clk);
                    check($sformatf("sweep_%0h", va), vid_data, pix(va));
                    va = va + 15'h0137;
                    if (va >= 15'h7D00) va = va - 15'h7C00;
                    vid_add = va;
                end
            end
        join

        repeat (4) @(negedge clk);
        check("no_we_in_video_slot", bad_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
